// File: rtl/usb_if_pkg.sv
// Shared host-interface definitions: serial TX arbiter state encoding and defaults.
package usb_if_pkg;

  typedef enum logic [2:0] {
    TXARB_IDLE  = 3'd0,
    TXARB_GRANT = 3'd1,
    TXARB_START = 3'd2,
    TXARB_GUARD = 3'd3,
    TXARB_DRAIN = 3'd4
  } txarb_state_t;

  localparam int TXARB_TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// wrapping modulo NUM_REQ (not modulo a power of two).
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int cand;
    cand    = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[cand[PTR_W-1:0]]) begin
        o_any                    = 1'b1;
        o_grant[cand[PTR_W-1:0]] = 1'b1;
        o_idx                    = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin, packet-locked sharing of the serial transmitter among byte requesters.
// Optional mid-packet idle timeout is built only when TX_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner, arbitrate among req_valid
// GRANT | owner holds the lock, waiting for its next byte
// START | tx_start / req_ready pulse cycle
// GUARD | transmitter busy flag not yet valid, ignore it
// DRAIN | wait for tx_busy to fall, then next byte or release
module serial_tx_arbiter
  import usb_if_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = TXARB_TIMEOUT_DEFAULT
) (
  input  logic                 ftdi_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_flag
);

  localparam int PTR_W = $clog2(NUM_REQ);

  txarb_state_t       r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_last, w_last_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_timeout_hit;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [7:0]         w_owner_byte;
  logic               w_owner_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_owner_byte  = req_data[{r_owner, 3'b000} +: 8];
  assign w_owner_valid = req_valid[r_owner];

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  // Counts consecutive GRANT cycles without a byte from the owner.
  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (r_state != TXARB_GRANT || w_owner_valid) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign w_timeout_hit = (r_state == TXARB_GRANT) && !w_owner_valid &&
                         (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_nxt     = r_grant;
    w_tx_data_nxt   = r_tx_data;
    w_last_nxt      = r_last;
    w_tx_start_nxt  = 1'b0;
    w_req_ready_nxt = '0;
    w_timeout_nxt   = r_timeout;
    case (r_state)
      TXARB_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_grant;
          w_owner_nxt = w_pick_idx;
          w_state_nxt = TXARB_GRANT;
        end
      end
      TXARB_GRANT: begin
        if (w_owner_valid) begin
          w_tx_data_nxt   = w_owner_byte;
          w_last_nxt      = req_last[r_owner];
          w_tx_start_nxt  = 1'b1;
          w_req_ready_nxt = r_grant;
          w_state_nxt     = TXARB_START;
        end else if (w_timeout_hit) begin
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_rr_ptr_nxt  = r_owner;
          w_state_nxt   = TXARB_IDLE;
        end
      end
      TXARB_START: w_state_nxt = TXARB_GUARD;
      TXARB_GUARD: w_state_nxt = TXARB_DRAIN;
      TXARB_DRAIN: begin
        if (!tx_busy) begin
          if (r_last) begin
            w_rr_ptr_nxt = r_owner;
            w_grant_nxt  = '0;
            w_state_nxt  = TXARB_IDLE;
          end else begin
            w_state_nxt = TXARB_GRANT;
          end
        end
      end
      default: w_state_nxt = TXARB_IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      r_state     <= TXARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_req_ready <= '0;
      r_tx_data   <= 8'h00;
      r_last      <= 1'b0;
      r_tx_start  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_last      <= w_last_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign req_ready    = r_req_ready;
  assign grant        = r_grant;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed packets plus random traffic against a
// transaction-level timing/ordering model. Timeout test needs TX_ARB_TIMEOUT_EN.
module tb_serial_tx_arbiter;

  localparam int N = 3;

  logic           ftdi_clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           timeout_flag;

  always #5 ftdi_clk = ~ftdi_clk;

  serial_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .ftdi_clk     (ftdi_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .timeout_flag (timeout_flag)
  );

  // per-requester pending bytes, {last, data}
  logic [8:0] pq [N][$];
  logic [7:0] tx_log[$];
  int         start_log[$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit m_on = 1'b1;
  int m_phase, m_owner, m_ptr, m_idle_from, m_next_start, m_drain_from;
  int m_grant_from, m_grant_until;
  bit m_gvalid, m_wait_drain, m_cur_last;
  logic [7:0] m_tx_data;
  int busy_len = 2, busy_cnt = 0, gate_pct = 0;
  bit busy_hold = 1'b0, rand_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int rr_next(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic enq(input int i, input logic [7:0] d, input bit last);
    pq[i].push_back({last, d});
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) pq[i].delete();
    m_phase = 0; m_owner = 0; m_ptr = N - 1; m_next_start = -1;
    m_gvalid = 0; m_grant_from = 0; m_grant_until = -1;
    m_wait_drain = 0; m_cur_last = 0; m_tx_data = 8'h00;
    busy_cnt = 0; busy_hold = 0;
  endtask

  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] eg;
    bit es;
    @(posedge ftdi_clk); #1; cyc++;
    if (tx_start) begin
      tx_log.push_back(tx_data);
      start_log.push_back(cyc);
    end
    if (!m_on) return;
    es = (cyc == m_next_start);
    if (es) m_tx_data = pq[m_owner][0][7:0];
    eg = (m_gvalid && cyc >= m_grant_from && (m_grant_until < 0 || cyc < m_grant_until))
         ? N'(1 << m_owner) : '0;
    chk("tx_start", tx_start, es);
    chk("req_ready", req_ready, es ? (1 << m_owner) : 0);
    chk("grant", grant, eg);
    chk("tx_data", tx_data, m_tx_data);
    chk("timeout_flag", timeout_flag, 0);
    if (es) begin
      m_cur_last = pq[m_owner][0][8];
      void'(pq[m_owner].pop_front());
      m_drain_from = cyc + 2; m_wait_drain = 1; m_next_start = -1;
      busy_cnt = rand_busy ? $urandom_range(0, 4) : busy_len;
      busy_hold = 1;
    end
    // transmitter: busy rises one cycle after start
    if (busy_hold) begin tx_busy = 0; busy_hold = 0; end
    else if (busy_cnt > 0) begin tx_busy = 1; busy_cnt--; end
    else tx_busy = 0;
    if (m_wait_drain && cyc >= m_drain_from && !tx_busy) begin
      m_wait_drain = 0;
      if (m_cur_last) begin
        m_grant_until = cyc + 1; m_ptr = m_owner; m_phase = 0; m_idle_from = cyc + 1;
      end else m_next_start = cyc + 2;
    end
    for (int i = 0; i < N; i++) begin
      bit keep;
      keep = (m_phase == 1 && i == m_owner) || ($urandom_range(0, 99) >= gate_pct);
      v[i] = (pq[i].size() > 0) && keep;
      req_data[i*8 +: 8] = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
      req_last[i] = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
    end
    req_valid = v;
    if (m_phase == 0 && cyc >= m_idle_from && v != '0) begin
      m_owner = rr_next(m_ptr, v); m_phase = 1; m_gvalid = 1;
      m_grant_from = cyc + 1; m_grant_until = -1; m_next_start = cyc + 2;
    end
  endtask

  task automatic do_reset();
    reset = 1; req_valid = '0; req_last = '0; req_data = '0; tx_busy = 0;
    repeat (2) begin @(posedge ftdi_clk); #1; cyc++; end
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_timeout", timeout_flag, 0);
    model_clear();
    tx_log.delete(); start_log.delete();
    m_on = 1; reset = 0; m_idle_from = cyc;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() > 0 || m_phase == 1 || m_wait_drain)
           && n < budget) begin
      step(); n++;
    end
    chk("run_budget_expired", n >= budget, 0);
    repeat (3) step();
  endtask

  task automatic chk_log(input string tag, input logic [7:0] e[$]);
    chk({tag, "_count"}, tx_log.size(), e.size());
    for (int i = 0; i < e.size() && i < tx_log.size(); i++) chk(tag, tx_log[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, n;
    logic [7:0] e[$];

    // 1: reset values and single-byte latency
    do_reset();
    t0 = cyc + 1;
    enq(0, 8'h5A, 1);
    run_idle(200);
    chk("t1_starts", start_log.size(), 1);
    if (start_log.size() > 0) chk("t1_latency", start_log[0] - t0, 2);
    e = '{8'h5A}; chk_log("t1_data", e);

    // 2: packet lock
    do_reset();
    enq(0, 8'h01, 0); enq(0, 8'h02, 0); enq(0, 8'h03, 1); enq(1, 8'h77, 1);
    run_idle(300);
    e = '{8'h01, 8'h02, 8'h03, 8'h77}; chk_log("t2_order", e);

    // 3: round-robin fairness
    do_reset();
    repeat (3) begin enq(0, 8'hA0, 1); enq(1, 8'hB1, 1); enq(2, 8'hC2, 1); end
    run_idle(500);
    e = '{8'hA0, 8'hB1, 8'hC2, 8'hA0, 8'hB1, 8'hC2, 8'hA0, 8'hB1, 8'hC2};
    chk_log("t3_order", e);

    // 4: busy hold-off of 100 cycles
    do_reset();
    busy_len = 100;
    enq(0, 8'h41, 0); enq(0, 8'h42, 1); enq(1, 8'h43, 1);
    run_idle(1000);
    chk("t4_starts", start_log.size(), 3);
    if (start_log.size() >= 3) begin
      chk("t4_same_pkt_gap", start_log[1] - start_log[0], 103);
      chk("t4_next_pkt_gap", start_log[2] - start_log[1], 104);
    end
    busy_len = 2;

    // 5: random traffic, random busy, non-owners dropping valid
    do_reset();
    rand_busy = 1; gate_pct = 30;
    for (int p = 0; p < 30; p++) begin
      int r, len;
      r = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) enq(r, 8'($urandom), b == len - 1);
      repeat ($urandom_range(0, 12)) step();
    end
    run_idle(5000);
    rand_busy = 0; gate_pct = 0;

    // 6: reset in the middle of DRAIN
    do_reset();
    busy_len = 10;
    for (int b = 0; b < 4; b++) enq(1, 8'h60 + 8'(b), b == 3);
    n = 0;
    while (start_log.size() < 2 && n < 100) begin step(); n++; end
    chk("t6_reached_second_byte", start_log.size(), 2);
    repeat (3) step();
    chk("t6_grant_before", grant, 3'b010);
    #2 reset = 1;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_tx_start", tx_start, 0);
    chk("t6_tx_data", tx_data, 8'h00);
    chk("t6_req_ready", req_ready, 0);
    busy_len = 2;
    do_reset();
    enq(1, 8'h70, 1); enq(0, 8'h71, 1);
    run_idle(300);
    e = '{8'h71, 8'h70}; chk_log("t6_after", e);

`ifdef TX_ARB_TIMEOUT_EN
    // 7: lock broken by idle timeout
    do_reset();
    m_on = 0;
    req_valid = 3'b001; req_data = 24'h000011; req_last = 3'b000;
    n = 0;
    while (!tx_start && n < 10) begin step(); n++; end
    chk("t7_first_start", tx_start, 1);
    s = cyc;
    req_valid = 3'b010; req_data = 24'h003300; req_last = 3'b010;
    while (cyc < s + 18) step();
    chk("t7_flag_before", timeout_flag, 0);
    chk("t7_grant_before", grant, 3'b001);
    step();
    chk("t7_flag_set", timeout_flag, 1);
    chk("t7_grant_released", grant, 0);
    step(); step();
    chk("t7_req1_start", tx_start, 1);
    chk("t7_req1_data", tx_data, 8'h33);
    chk("t7_req1_grant", grant, 3'b010);
    chk("t7_req1_ready", req_ready, 3'b010);
    req_valid = '0;
    repeat (5) step();
    chk("t7_flag_sticky", timeout_flag, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
